// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit adder among N_REQ requesters.
// Optional response statistics enabled by defining ADDER_SHARE_ARBITER_STATS_EN.
module adder_share_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned ID_W  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WIDTH-1:0]       rsp_sum,
  output logic                   rsp_carry,
  output logic [ID_W-1:0]        rsp_id
`ifdef ADDER_SHARE_ARBITER_STATS_EN
  ,
  output logic [15:0]            stat_count,
  output logic [15:0]            stat_ovf
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   last_grant_q, last_grant_d;
  logic [ID_W-1:0]   cur_id_q, cur_id_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0]  op_a_q, op_a_d;
  logic [WIDTH-1:0]  op_b_q, op_b_d;
  logic [WIDTH-1:0]  rsp_sum_q, rsp_sum_d;
  logic              rsp_carry_q, rsp_carry_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              win_found;
  logic [ID_W-1:0]   win_id;
  logic [ID_W-1:0]   sel;
  logic [WIDTH:0]    add_res;
  int unsigned       idx;

  // Scan starts one past the last grant and wraps, so the most recent winner is checked last.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    sel       = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      idx = 32'(last_grant_q) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      sel = idx[ID_W-1:0];
      if (!win_found && req_valid[sel]) begin
        win_found = 1'b1;
        win_id    = sel;
      end
    end
  end

  assign add_res = {1'b0, op_a_q} + {1'b0, op_b_q};

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cur_id_d     = cur_id_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    rsp_sum_d    = rsp_sum_q;
    rsp_carry_d  = rsp_carry_q;
    rsp_id_d     = rsp_id_q;
    rsp_valid_d  = rsp_valid_q;
    req_ready    = '0;
    case (state_q)
      IDLE: begin
        if (win_found && !rst) begin
          req_ready[win_id] = 1'b1;
          op_a_d            = req_a[win_id*WIDTH +: WIDTH];
          op_b_d            = req_b[win_id*WIDTH +: WIDTH];
          cur_id_d          = win_id;
          last_grant_d      = win_id;
          state_d           = EXEC;
        end
      end
      EXEC: begin
        rsp_sum_d   = add_res[WIDTH-1:0];
        rsp_carry_d = add_res[WIDTH];
        rsp_id_d    = cur_id_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= ID_W'(N_REQ - 1);
      cur_id_q     <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      rsp_sum_q    <= '0;
      rsp_carry_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cur_id_q     <= cur_id_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      rsp_sum_q    <= rsp_sum_d;
      rsp_carry_q  <= rsp_carry_d;
      rsp_id_q     <= rsp_id_d;
      rsp_valid_q  <= rsp_valid_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_carry = rsp_carry_q;
  assign rsp_id    = rsp_id_q;

`ifdef ADDER_SHARE_ARBITER_STATS_EN
  logic [15:0] stat_count_q, stat_count_d;
  logic [15:0] stat_ovf_q, stat_ovf_d;
  logic        rsp_fire;

  assign rsp_fire = rsp_valid_q & rsp_ready;

  always_comb begin
    stat_count_d = stat_count_q;
    stat_ovf_d   = stat_ovf_q;
    if (rsp_fire && stat_count_q != 16'hFFFF) stat_count_d = stat_count_q + 16'd1;
    if (rsp_fire && rsp_carry_q && stat_ovf_q != 16'hFFFF) stat_ovf_d = stat_ovf_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_count_q <= '0;
      stat_ovf_q   <= '0;
    end else begin
      stat_count_q <= stat_count_d;
      stat_ovf_q   <= stat_ovf_d;
    end
  end

  assign stat_count = stat_count_q;
  assign stat_ovf   = stat_ovf_q;
`endif

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed self-checking bench for adder_share_arbiter (N_REQ=4, WIDTH=8).
module tb_adder_share_arbiter;
  localparam int unsigned N_REQ = 4;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned ID_W  = 2;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic [N_REQ-1:0]       req_valid = '0;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*WIDTH-1:0] req_a = '0;
  logic [N_REQ*WIDTH-1:0] req_b = '0;
  logic                   rsp_valid;
  logic                   rsp_ready = 1'b0;
  logic [WIDTH-1:0]       rsp_sum;
  logic                   rsp_carry;
  logic [ID_W-1:0]        rsp_id;
`ifdef ADDER_SHARE_ARBITER_STATS_EN
  logic [15:0]            stat_count;
  logic [15:0]            stat_ovf;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  adder_share_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum), .rsp_carry(rsp_carry), .rsp_id(rsp_id)
`ifdef ADDER_SHARE_ARBITER_STATS_EN
    , .stat_count(stat_count), .stat_ovf(stat_ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = 4'b1111; rsp_ready = 1'b1;
    #1;
    total_cnt++;
    if (req_ready !== 4'b0000) $display("FAIL rst_req_ready got=%b exp=0000", req_ready); else pass_cnt++;
    total_cnt++;
    if ({rsp_valid, rsp_carry, rsp_sum, rsp_id} !== 12'h000)
      $display("FAIL rst_rsp got v=%b c=%b s=%h id=%0d exp all 0", rsp_valid, rsp_carry, rsp_sum, rsp_id);
    else pass_cnt++;
`ifdef ADDER_SHARE_ARBITER_STATS_EN
    total_cnt++;
    if ({stat_count, stat_ovf} !== 32'h0) $display("FAIL rst_stats got=%h/%h exp=0/0", stat_count, stat_ovf); else pass_cnt++;
`endif
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 4'b0100; req_a[2*WIDTH +: WIDTH] = 8'd25; req_b[2*WIDTH +: WIDTH] = 8'd17; rsp_ready = 1'b1;
    #1;
    total_cnt++;
    if (req_ready !== 4'b0100) $display("FAIL single_ready got=%b exp=0100", req_ready); else pass_cnt++;
    @(negedge clk);
    req_valid = '0;
    total_cnt++;
    if (rsp_valid !== 1'b0 || req_ready !== 4'b0000)
      $display("FAIL single_exec got v=%b rdy=%b exp v=0 rdy=0000", rsp_valid, req_ready);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (rsp_valid !== 1'b1 || rsp_sum !== 8'd42 || rsp_carry !== 1'b0 || rsp_id !== 2'd2)
      $display("FAIL single_rsp got v=%b s=%0d c=%b id=%0d exp v=1 s=42 c=0 id=2", rsp_valid, rsp_sum, rsp_carry, rsp_id);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (rsp_valid !== 1'b0 || rsp_sum !== 8'd42)
      $display("FAIL single_after got v=%b s=%0d exp v=0 s=42", rsp_valid, rsp_sum);
    else pass_cnt++;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_rdy;
    logic [7:0] exp_sum;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req_a[i*WIDTH +: WIDTH] = 8'(10 * (i + 1));
      req_b[i*WIDTH +: WIDTH] = 8'(i + 1);
    end
    req_valid = 4'b1111; rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      exp_rdy = 4'b0001 << (k % 4);
      exp_sum = 8'(11 * ((k % 4) + 1));
      #1;
      total_cnt++;
      if (req_ready !== exp_rdy) $display("FAIL rr_grant%0d got=%b exp=%b", k, req_ready, exp_rdy); else pass_cnt++;
      @(negedge clk);
      @(negedge clk);
      total_cnt++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'(k % 4) || rsp_sum !== exp_sum)
        $display("FAIL rr_rsp%0d got v=%b id=%0d s=%0d exp v=1 id=%0d s=%0d", k, rsp_valid, rsp_id, rsp_sum, k % 4, exp_sum);
      else pass_cnt++;
      @(negedge clk);
    end
    req_valid = '0;
  endtask

  task automatic test_overflow();
    do_reset();
    req_valid = 4'b0001; req_a[7:0] = 8'hF0; req_b[7:0] = 8'h20; rsp_ready = 1'b1;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    total_cnt++;
    if (rsp_valid !== 1'b1 || rsp_sum !== 8'h10 || rsp_carry !== 1'b1 || rsp_id !== 2'd0)
      $display("FAIL ovf_rsp got v=%b s=%h c=%b id=%0d exp v=1 s=10 c=1 id=0", rsp_valid, rsp_sum, rsp_carry, rsp_id);
    else pass_cnt++;
    @(negedge clk);
`ifdef ADDER_SHARE_ARBITER_STATS_EN
    total_cnt++;
    if (stat_count !== 16'd1 || stat_ovf !== 16'd1)
      $display("FAIL ovf_stats got cnt=%0d ovf=%0d exp 1/1", stat_count, stat_ovf);
    else pass_cnt++;
`endif
  endtask

  task automatic test_backpressure();
    do_reset();
    req_valid = 4'b0110; rsp_ready = 1'b0;
    req_a[1*WIDTH +: WIDTH] = 8'd3;  req_b[1*WIDTH +: WIDTH] = 8'd4;
    req_a[2*WIDTH +: WIDTH] = 8'd50; req_b[2*WIDTH +: WIDTH] = 8'd60;
    #1;
    total_cnt++;
    if (req_ready !== 4'b0010) $display("FAIL bp_grant got=%b exp=0010", req_ready); else pass_cnt++;
    @(negedge clk);
    req_valid = 4'b0100;
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      total_cnt++;
      if (rsp_valid !== 1'b1 || rsp_sum !== 8'd7 || rsp_carry !== 1'b0 || rsp_id !== 2'd1 || req_ready !== 4'b0000)
        $display("FAIL bp_hold%0d got v=%b s=%0d c=%b id=%0d rdy=%b exp v=1 s=7 c=0 id=1 rdy=0000",
                 c, rsp_valid, rsp_sum, rsp_carry, rsp_id, req_ready);
      else pass_cnt++;
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (rsp_valid !== 1'b0 || req_ready !== 4'b0100 || rsp_sum !== 8'd7 || rsp_id !== 2'd1)
      $display("FAIL bp_release got v=%b rdy=%b s=%0d id=%0d exp v=0 rdy=0100 s=7 id=1", rsp_valid, req_ready, rsp_sum, rsp_id);
    else pass_cnt++;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    total_cnt++;
    if (rsp_valid !== 1'b1 || rsp_sum !== 8'd110 || rsp_id !== 2'd2)
      $display("FAIL bp_next got v=%b s=%0d id=%0d exp v=1 s=110 id=2", rsp_valid, rsp_sum, rsp_id);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_valid = 4'b1000; req_a[3*WIDTH +: WIDTH] = 8'd1; req_b[3*WIDTH +: WIDTH] = 8'd1; rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    total_cnt++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd3) $display("FAIL mid_pre got v=%b id=%0d exp v=1 id=3", rsp_valid, rsp_id); else pass_cnt++;
    rst = 1'b1;
    #1;
    total_cnt++;
    if (rsp_valid !== 1'b0 || rsp_sum !== 8'd0 || rsp_id !== 2'd0)
      $display("FAIL mid_async got v=%b s=%0d id=%0d exp 0/0/0", rsp_valid, rsp_sum, rsp_id);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    req_valid = 4'b1001;
    #1;
    total_cnt++;
    if (req_ready !== 4'b0001) $display("FAIL mid_grant got=%b exp=0001", req_ready); else pass_cnt++;
    @(negedge clk);
    req_valid = '0; rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_idle();
    int bad;
    do_reset();
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (req_ready !== 4'b0000 || rsp_valid !== 1'b0) bad++;
    end
    total_cnt++;
    if (bad !== 0) $display("FAIL idle_quiet got %0d bad cycles exp 0", bad); else pass_cnt++;
    req_valid = 4'b1000; req_a[3*WIDTH +: WIDTH] = 8'd200; req_b[3*WIDTH +: WIDTH] = 8'd100; rsp_ready = 1'b1;
    #1;
    total_cnt++;
    if (req_ready !== 4'b1000) $display("FAIL idle_grant got=%b exp=1000", req_ready); else pass_cnt++;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    total_cnt++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_sum !== 8'd44 || rsp_carry !== 1'b1)
      $display("FAIL idle_rsp got v=%b id=%0d s=%0d c=%b exp v=1 id=3 s=44 c=1", rsp_valid, rsp_id, rsp_sum, rsp_carry);
    else pass_cnt++;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    test_idle();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/adder_share_arbiter.md
Name: adder_share_arbiter

Overview:
- Round-robin arbiter that shares one WIDTH-bit combinational adder between N_REQ requesters.
- Each requester offers an operand pair over a valid/ready handshake. The arbiter grants one requester, computes the sum, and returns it with the requester ID over a single valid/ready response channel.
- Sits between requester logic (counters, datapath stages) and the shared adder instance.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- WIDTH, 8, operand and sum width in bits.
- ID_W, 2, requester ID width; must equal clog2(N_REQ), minimum 1.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req_valid  input  N_REQ  per-requester operand valid.
- req_ready  output  N_REQ  per-requester accept; at most one bit high per cycle.
- req_a  input  N_REQ*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH].
- req_b  input  N_REQ*WIDTH  operand B, same packing as req_a.
- rsp_valid  output  1  result valid.
- rsp_ready  input  1  downstream accepts the result.
- rsp_sum  output  WIDTH  (a + b) mod 2^WIDTH.
- rsp_carry  output  1  carry out of the addition.
- rsp_id  output  ID_W  index of the requester that owns the result.

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_sum=0, rsp_carry=0, rsp_id=0, state=IDLE, last_grant=N_REQ-1 (so requester 0 has top priority after reset).
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Search req_valid starting at last_grant+1, wrapping modulo N_REQ; the first set bit wins.
  - req_ready[winner] is driven combinationally high in the same cycle; the transfer happens when valid & ready.
  - On transfer: register operands into op_a/op_b, winner into cur_id, update last_grant=winner, go to EXEC.
  - With no valid requests: all req_ready stay 0, remain in IDLE, last_grant unchanged.
- EXEC:
  - Compute {carry, sum} = op_a + op_b at WIDTH+1 bits.
  - Register the result into rsp_sum/rsp_carry and cur_id into rsp_id; set rsp_valid=1; go to RESP.
- RESP:
  - Hold rsp_valid and all rsp_* stable until rsp_ready=1.
  - On rsp_valid & rsp_ready: clear rsp_valid, go to IDLE.
  - rsp_sum/rsp_id keep their last value after the handshake.
- req_ready is 0 in EXEC and RESP; a requester's valid must stay asserted until accepted.
- Latency: acceptance in cycle T gives rsp_valid high in cycle T+2. With rsp_ready tied high, one transaction completes every 3 cycles.
- Fairness: with all requesters continuously valid, grants rotate 0,1,2,3,0,... No requester waits more than N_REQ-1 other grants.
- A requester dropping valid before being accepted is legal; it is simply skipped.
- Reset mid-operation (any state) returns immediately to IDLE. Any in-flight operand or result is discarded and rsp_valid drops asynchronously.
- Overflow: the sum wraps modulo 2^WIDTH and rsp_carry=1. No saturation.

Optional Feature:
- Macro ADDER_SHARE_ARBITER_STATS_EN.
- When defined:
  - Adds output stat_count [15:0]: count of completed response handshakes. Resets to 0, increments on rsp_valid & rsp_ready, saturates at 16'hFFFF.
  - Adds output stat_ovf [15:0]: same rules, incremented only for completed responses with rsp_carry=1.
- When undefined: both ports and their counters are absent; all other behaviour is identical.

Test Plan:
- Single request: after reset, req_valid=4'b0100 with a2=8'd25, b2=8'd17, rsp_ready=1 -> req_ready=4'b0100 in the same cycle; two cycles later rsp_valid=1, rsp_sum=42, rsp_carry=0, rsp_id=2.
- Round-robin: all four requesters valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0,1; each rsp_id matches; one response every 3 cycles.
- Overflow: a=8'hF0, b=8'h20 -> rsp_sum=8'h10, rsp_carry=1. With stats enabled: stat_ovf=1 and stat_count=1 after the handshake.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_* stable, req_ready=0 throughout; rsp_ready=1 -> handshake completes and the next grant occurs in the following cycle.
- Reset mid-operation: assert rst in RESP with rsp_valid=1 -> rsp_valid=0 immediately; after release req0 is granted first even though req3 was last served.
- Idle / no requests: req_valid=0 for 10 cycles -> req_ready=0, rsp_valid=0, state stays IDLE; a later req_valid=4'b1000 is granted to requester 3.
